// File: rtl/bw_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package : bw_mon_pkg
// Purpose : Shared types and helpers for the AXI bandwidth monitor.
//           - chan_result_t : per-channel scaled result (rate + saturation bit)
//           - SAT_MAX()     : all-ones value of a given width (up to MAX_W)
//           - sat_shift()   : left shift with saturation to a given width
// Config  : none (BW_MON_PEAK_EN is used by the monitor files only)
// Revision: 1.0  initial release
// ============================================================================
package bw_mon_pkg;

  // Widest counter the helpers support.
  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  // Result of scaling one channel's beat count to bytes.
  typedef struct packed {
    wide_t rate;  // scaled value, already clamped to the target width
    logic  sat;   // 1 when bits were lost by the clamp
  } chan_result_t;

  // All-ones value of width w (w <= MAX_W), zero-extended to MAX_W bits.
  function automatic wide_t SAT_MAX(input int unsigned w);
    wide_t m;
    m = '0;
    for (int unsigned b = 0; b < MAX_W; b++) begin
      if (b < w) m[b] = 1'b1;
    end
    return m;
  endfunction

  // val << sh, clamped to SAT_MAX(w). The shift is done at double width so
  // no bit can fall off the top before the comparison.
  function automatic chan_result_t sat_shift(input wide_t       val,
                                             input int unsigned w,
                                             input int unsigned sh);
    logic [2*MAX_W-1:0] wide;
    logic [2*MAX_W-1:0] lim;
    chan_result_t       r;
    wide = {{MAX_W{1'b0}}, val} << sh;
    lim  = {{MAX_W{1'b0}}, SAT_MAX(w)};
    if (wide > lim) begin
      r.rate = SAT_MAX(w);
      r.sat  = 1'b1;
    end else begin
      r.rate = wide[MAX_W-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage : bw_mon_pkg
`default_nettype wire

// File: rtl/bw_chan_counter.sv
`default_nettype none
// ============================================================================
// Module  : bw_chan_counter
// Purpose : One monitored channel: saturating beat counter, byte scaling at
//           the window terminal count, result register, sticky saturation
//           flag and (optionally) peak-hold register.
// Ports   : clk, reset        clock, synchronous active-high reset
//           enable_i          counting enabled this cycle
//           clear_i           synchronous clear (beats every other event)
//           tc_i              window terminal count this cycle
//           valid_i, ready_i  handshake pair being monitored
//           rate_o            bytes in last completed window
//           sat_o             sticky saturation flag
//           peak_o            max rate_o seen (BW_MON_PEAK_EN only)
// Config  : BW_MON_PEAK_EN  enables peak_o and the peak register
// Params  : CNT_W <= 63
// Revision: 1.0  initial release
// ============================================================================
module bw_chan_counter
  import bw_mon_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned BEAT_BYTES_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             tc_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] rate_o,
  output logic             sat_o
`ifdef BW_MON_PEAK_EN
  ,
  output logic [CNT_W-1:0] peak_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             sat_q,  sat_d;
`ifdef BW_MON_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;
`endif

  logic             w_beat;
  logic             w_at_max;
  logic [CNT_W:0]   w_next;
  chan_result_t     w_scaled;
  logic [CNT_W-1:0] w_new_rate;
  logic             w_scale_sat;

  assign w_beat   = valid_i & ready_i & enable_i;
  assign w_at_max = (cnt_q == CNT_MAX);

  // One bit wider than the counter: a beat in the TC cycle on a full
  // counter must still be seen as an overflow by the scaler.
  assign w_next   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, w_beat};
  assign w_scaled = sat_shift(wide_t'(w_next), CNT_W, BEAT_BYTES_LOG2);

  assign w_new_rate = w_scaled.rate[CNT_W-1:0];
  // Bits above CNT_W are zero after the clamp; folding them in keeps the
  // flag conservative should that ever not hold.
  assign w_scale_sat = w_scaled.sat | (|w_scaled.rate[MAX_W-1:CNT_W]);

  always_comb begin
    cnt_d  = cnt_q;
    rate_d = rate_q;
    sat_d  = sat_q;
`ifdef BW_MON_PEAK_EN
    peak_d = peak_q;
`endif
    if (clear_i) begin
      cnt_d  = '0;
      rate_d = '0;
      sat_d  = 1'b0;
`ifdef BW_MON_PEAK_EN
      peak_d = '0;
`endif
    end else if (tc_i) begin
      // Window closes: the TC-cycle beat is already included in w_next.
      cnt_d  = '0;
      rate_d = w_new_rate;
      sat_d  = sat_q | w_scale_sat;
`ifdef BW_MON_PEAK_EN
      if (w_new_rate > peak_q) peak_d = w_new_rate;
`endif
    end else if (w_beat) begin
      if (w_at_max) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rate_q <= '0;
      sat_q  <= 1'b0;
`ifdef BW_MON_PEAK_EN
      peak_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
      sat_q  <= sat_d;
`ifdef BW_MON_PEAK_EN
      peak_q <= peak_d;
`endif
    end
  end

  assign rate_o = rate_q;
  assign sat_o  = sat_q;
`ifdef BW_MON_PEAK_EN
  assign peak_o = peak_q;
`endif

endmodule : bw_chan_counter
`default_nettype wire

// File: rtl/axi_bw_monitor.sv
`default_nettype none
// ============================================================================
// Module  : axi_bw_monitor
// Purpose : Multi-channel bandwidth monitor. Counts valid&&ready beats per
//           channel over a programmable window and publishes bytes per window.
// Ports   : clk, reset      clock, synchronous active-high reset
//           enable_i        1: window advances, beats counted; 0: freeze
//           clear_i         synchronous clear of counters, results, flags
//           hs_valid_i      per-channel VALID
//           hs_ready_i      per-channel READY
//           win_tick_o      1-cycle pulse: results updated this cycle
//           rate_bytes_o    bytes in last window, ch i at [i*CNT_W +: CNT_W]
//           sat_flag_o      sticky per-channel saturation
//           win_count_o     completed windows since reset/clear (wraps)
//           peak_bytes_o    max rate per channel (BW_MON_PEAK_EN only)
// Config  : BW_MON_PEAK_EN  adds peak-hold registers and peak_bytes_o
// Params  : WINDOW_CYC >= 2, CNT_W <= 63
// Revision: 1.0  initial release
// ============================================================================
module axi_bw_monitor
  import bw_mon_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned WINDOW_CYC      = 300_120_000,
  parameter int unsigned BEAT_BYTES_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       hs_valid_i,
  input  logic [NUM_CH-1:0]       hs_ready_i,
  output logic                    win_tick_o,
  output logic [NUM_CH*CNT_W-1:0] rate_bytes_o,
  output logic [NUM_CH-1:0]       sat_flag_o,
  output logic [CNT_W-1:0]        win_count_o
`ifdef BW_MON_PEAK_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] peak_bytes_o
`endif
);

  localparam int unsigned      WIN_W    = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             tick_q,    tick_d;
  logic [CNT_W-1:0] wcount_q,  wcount_d;

  logic             w_tc;

  // Terminal count only while enabled; a clear in the same cycle discards
  // the closing window, so it also masks TC for the channels.
  assign w_tc = enable_i & ~clear_i & (win_cnt_q == WIN_LAST);

  always_comb begin
    win_cnt_d = win_cnt_q;
    wcount_d  = wcount_q;
    tick_d    = w_tc;
    if (clear_i) begin
      win_cnt_d = '0;
      wcount_d  = '0;
    end else if (enable_i) begin
      if (w_tc) begin
        win_cnt_d = '0;
        wcount_d  = wcount_q + 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q <= '0;
      wcount_q  <= '0;
      tick_q    <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      wcount_q  <= wcount_d;
      tick_q    <= tick_d;
    end
  end

  assign win_tick_o  = tick_q;
  assign win_count_o = wcount_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bw_chan_counter #(
      .CNT_W           (CNT_W),
      .BEAT_BYTES_LOG2 (BEAT_BYTES_LOG2)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .enable_i (enable_i),
      .clear_i  (clear_i),
      .tc_i     (w_tc),
      .valid_i  (hs_valid_i[i]),
      .ready_i  (hs_ready_i[i]),
      .rate_o   (rate_bytes_o[i*CNT_W +: CNT_W]),
      .sat_o    (sat_flag_o[i])
`ifdef BW_MON_PEAK_EN
      ,
      .peak_o   (peak_bytes_o[i*CNT_W +: CNT_W])
`endif
    );
  end : g_ch

endmodule : axi_bw_monitor
`default_nettype wire

// File: tb/tb_axi_bw_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_bw_monitor
// Purpose : Self-checking bench for axi_bw_monitor. A main instance
//           (100-cycle window) is checked every cycle against a behavioural
//           model; a second instance (10000-cycle window) covers saturation.
// Config  : BW_MON_PEAK_EN  also checks peak_bytes_o
// Revision: 1.0  initial release
// ============================================================================
module tb_axi_bw_monitor;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int WIN    = 100;
  localparam int BIGWIN = 10000;
  localparam int LOG2B  = 3;
  localparam longint MAXV = 65535;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic                    en = 1'b0, clr = 1'b0;
  logic [NUM_CH-1:0]       hv = '0, hr = '0;
  logic                    tick;
  logic [NUM_CH*CNT_W-1:0] rate;
  logic [NUM_CH-1:0]       sat;
  logic [CNT_W-1:0]        wcnt;
`ifdef BW_MON_PEAK_EN
  logic [NUM_CH*CNT_W-1:0] peak;
`endif

  // saturation instance
  logic                    b_en = 1'b0, b_clr = 1'b0;
  logic [NUM_CH-1:0]       b_hv = '0, b_hr = '0;
  logic                    b_tick;
  logic [NUM_CH*CNT_W-1:0] b_rate;
  logic [NUM_CH-1:0]       b_sat;
  logic [CNT_W-1:0]        b_wcnt;
`ifdef BW_MON_PEAK_EN
  logic [NUM_CH*CNT_W-1:0] b_peak;
`endif

  axi_bw_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW_CYC(WIN),
                   .BEAT_BYTES_LOG2(LOG2B)) u_dut (
    .clk(clk), .reset(reset), .enable_i(en), .clear_i(clr),
    .hs_valid_i(hv), .hs_ready_i(hr), .win_tick_o(tick),
    .rate_bytes_o(rate), .sat_flag_o(sat), .win_count_o(wcnt)
`ifdef BW_MON_PEAK_EN
    , .peak_bytes_o(peak)
`endif
  );

  axi_bw_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW_CYC(BIGWIN),
                   .BEAT_BYTES_LOG2(LOG2B)) u_dut_big (
    .clk(clk), .reset(reset), .enable_i(b_en), .clear_i(b_clr),
    .hs_valid_i(b_hv), .hs_ready_i(b_hr), .win_tick_o(b_tick),
    .rate_bytes_o(b_rate), .sat_flag_o(b_sat), .win_count_o(b_wcnt)
`ifdef BW_MON_PEAK_EN
    , .peak_bytes_o(b_peak)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main instance) ----------------
  int     m_pos;
  longint m_beats [NUM_CH];
  bit     m_tick;
  longint m_rate  [NUM_CH];
  bit     m_sat   [NUM_CH];
  longint m_wc;
  longint m_peak  [NUM_CH];

  always @(posedge clk) begin
    if (reset || clr) begin
      m_pos = 0; m_tick = 0; m_wc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_beats[c] = 0; m_rate[c] = 0; m_sat[c] = 0; m_peak[c] = 0;
      end
    end else begin
      m_tick = 0;
      if (en) begin
        for (int c = 0; c < NUM_CH; c++)
          if (hv[c] && hr[c]) m_beats[c]++;
        if (m_pos == WIN - 1) begin
          for (int c = 0; c < NUM_CH; c++) begin
            longint bytes;
            bytes = m_beats[c] * (64'sd1 << LOG2B);
            if (bytes > MAXV) begin
              m_rate[c] = MAXV;
              m_sat[c]  = 1;
            end else begin
              m_rate[c] = bytes;
            end
            if (m_rate[c] > m_peak[c]) m_peak[c] = m_rate[c];
            m_beats[c] = 0;
          end
          m_wc   = (m_wc + 1) % 65536;
          m_tick = 1;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tick", tick, m_tick);
      check("win_count", wcnt, m_wc);
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("rate%0d", c), rate[c*CNT_W +: CNT_W], m_rate[c]);
        check($sformatf("sat%0d", c), sat[c], m_sat[c]);
`ifdef BW_MON_PEAK_EN
        check($sformatf("peak%0d", c), peak[c*CNT_W +: CNT_W], m_peak[c]);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

`ifdef BW_MON_PEAK_EN
  int w_beats [3] = '{40, 90, 20};
  int w_peak  [3] = '{320, 720, 720};
`endif

  initial begin
    step();
    chk_en = 1'b1;   // reset state compared by the model
    step();
    check("reset_tick", tick, 0);
    check("reset_rate", rate, 0);
    check("reset_sat", sat, 0);
    check("reset_wcnt", wcnt, 0);
    reset = 1'b0;

    // 1: ch0 beats every cycle, ch1 idle
    do_clear();
    en = 1'b1; hv = 2'b01; hr = 2'b01;
    repeat (WIN - 1) step();
    check("t1_no_early_tick", tick, 0);
    step();
    check("t1_tick", tick, 1);
    check("t1_rate0", rate[15:0], 800);
    check("t1_rate1", rate[31:16], 0);
    check("t1_wcnt", wcnt, 1);
    hv = 2'b00; hr = 2'b00;
    step();
    check("t1_tick_1cyc", tick, 0);
    check("t1_rate_hold", rate[15:0], 800);

    // 2: ch1 beat only in the TC cycle
    do_clear();
    repeat (WIN - 1) step();
    hv = 2'b10; hr = 2'b10;
    step();
    hv = 2'b00; hr = 2'b00;
    check("t2_tick", tick, 1);
    check("t2_rate1", rate[31:16], 8);
    check("t2_rate0", rate[15:0], 0);
    repeat (WIN) step();
    check("t2_tick2", tick, 1);
    check("t2_rate1_next", rate[31:16], 0);

    // 3: enable low for 50 cycles mid-window
    do_clear();
    hv = 2'b01; hr = 2'b01;
    repeat (30) step();
    en = 1'b0;
    repeat (50) step();
    en = 1'b1;
    repeat (69) step();
    check("t3_no_tick_yet", tick, 0);
    step();
    check("t3_tick", tick, 1);
    check("t3_rate0", rate[15:0], 800);
    hv = 2'b00; hr = 2'b00;

    // 5: clear at cycle 60 of a window
    do_clear();
    repeat (60) begin
      hv = NUM_CH'($urandom); hr = NUM_CH'($urandom);
      step();
    end
    hv = 2'b11; hr = 2'b11;
    do_clear();
    check("t5_tick0", tick, 0);
    check("t5_rate0", rate, 0);
    check("t5_sat0", sat, 0);
    check("t5_wcnt0", wcnt, 0);
    repeat (WIN - 1) step();
    check("t5_no_tick", tick, 0);
    step();
    check("t5_tick", tick, 1);
    check("t5_wcnt", wcnt, 1);
    check("t5_rate", rate[15:0], 800);
    hv = 2'b00; hr = 2'b00;

`ifdef BW_MON_PEAK_EN
    // 6: peak hold over windows of 40, 90, 20 beats
    do_clear();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < WIN; k++) begin
        hv[0] = (k < w_beats[w]); hr[0] = (k < w_beats[w]);
        step();
      end
      check($sformatf("t6_peak_w%0d", w), peak[15:0], w_peak[w]);
    end
    hv = 2'b00; hr = 2'b00;
`endif

    // randomized traffic, enable gaps and occasional clears
    do_clear();
    repeat (20 * WIN) begin
      en  = ($urandom_range(0, 9) != 0);
      hv  = NUM_CH'($urandom);
      hr  = NUM_CH'($urandom);
      clr = ($urandom_range(0, 299) == 0);
      step();
    end
    clr = 1'b0; en = 1'b0; hv = '0; hr = '0;

    // 4: saturation on the 10000-cycle instance
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    b_en = 1'b1; b_hv = 2'b01; b_hr = 2'b01;
    repeat (BIGWIN - 1) step();
    check("t4_no_tick", b_tick, 0);
    check("t4_sat_pre", b_sat, 0);
    step();
    check("t4_tick", b_tick, 1);
    check("t4_rate0", b_rate[15:0], 16'hFFFF);
    check("t4_rate1", b_rate[31:16], 0);
    check("t4_sat", b_sat, 2'b01);
    check("t4_wcnt", b_wcnt, 1);
`ifdef BW_MON_PEAK_EN
    check("t4_peak0", b_peak[15:0], 16'hFFFF);
`endif
    b_hv = 2'b00; b_hr = 2'b00;
    repeat (20) step();
    check("t4_sat_sticky", b_sat, 2'b01);
    b_clr = 1'b1;
    step();
    b_clr = 1'b0; b_en = 1'b0;
    check("t4_sat_cleared", b_sat, 0);
    check("t4_rate_cleared", b_rate, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axi_bw_monitor
`default_nettype wire
